// File: rtl/tune_cmd_decoder.sv
// Framed UART command decoder that writes the 64-bit NCO tuning word
// and sends ACK/NAK (plus the current word on QUERY) back over the UART.
module tune_cmd_decoder #(
    parameter logic [63:0] RESET_INC    = 64'h0104376A9DD10437,
    parameter int unsigned TIMEOUT_CLKS = 1000000
) (
    input  logic        osc_clk,
    input  logic        reset,
    input  logic        rx_dv,
    input  logic [7:0]  rx_byte,
    input  logic        tx_done,
    output logic [63:0] phase_inc,
    output logic        inc_update,
    output logic        tx_dv,
    output logic [7:0]  tx_byte,
    output logic        busy
);

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] CMD_SET   = 8'h01;
    localparam logic [7:0] CMD_ADD   = 8'h02;
    localparam logic [7:0] CMD_QUERY = 8'h03;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

    localparam logic [31:0] TO_MAX = 32'(TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_PAYLOAD,
        S_CSUM,
        S_EXEC,
        S_TX_SEND,
        S_TX_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [63:0] shadow_q, shadow_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  csum_q, csum_d;
    logic        csum_ok_q, csum_ok_d;
    logic [31:0] idle_q, idle_d;
    logic [63:0] phase_q, phase_d;
    logic        inc_q, inc_d;
    logic [7:0]  txb_q, txb_d;
    logic [63:0] reply_q, reply_d;
    logic [3:0]  rem_q, rem_d;

    logic in_frame;
    logic timeout;
    logic known_cmd;
    logic has_payload;

    assign in_frame = (state_q == S_CMD)
                   || (state_q == S_PAYLOAD)
                   || (state_q == S_CSUM);
    assign timeout  = (idle_q == TO_MAX);

    assign has_payload = (rx_byte == CMD_SET)
                      || (rx_byte == CMD_ADD);
    assign known_cmd   = (cmd_q == CMD_SET)
                      || (cmd_q == CMD_ADD)
                      || (cmd_q == CMD_QUERY);

    always_ff @(posedge osc_clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cmd_q     <= 8'h00;
            shadow_q  <= 64'h0;
            cnt_q     <= 3'd0;
            csum_q    <= 8'h00;
            csum_ok_q <= 1'b0;
            idle_q    <= 32'd0;
            phase_q   <= RESET_INC;
            inc_q     <= 1'b0;
            txb_q     <= 8'h00;
            reply_q   <= 64'h0;
            rem_q     <= 4'd0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            shadow_q  <= shadow_d;
            cnt_q     <= cnt_d;
            csum_q    <= csum_d;
            csum_ok_q <= csum_ok_d;
            idle_q    <= idle_d;
            phase_q   <= phase_d;
            inc_q     <= inc_d;
            txb_q     <= txb_d;
            reply_q   <= reply_d;
            rem_q     <= rem_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        shadow_d  = shadow_q;
        cnt_d     = cnt_q;
        csum_d    = csum_q;
        csum_ok_d = csum_ok_q;
        idle_d    = idle_q;
        phase_d   = phase_q;
        inc_d     = 1'b0;
        txb_d     = txb_q;
        reply_d   = reply_q;
        rem_d     = rem_q;

        // Inter-byte watchdog; a byte landing on the expiry cycle wins.
        if (in_frame) begin
            idle_d = rx_dv ? 32'd0 : idle_q + 32'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (rx_dv && (rx_byte == SYNC_BYTE)) begin
                    state_d  = S_CMD;
                    idle_d   = 32'd0;
                    cnt_d    = 3'd0;
                    shadow_d = 64'h0;
                end
            end
            S_CMD: begin
                if (rx_dv) begin
                    cmd_d   = rx_byte;
                    csum_d  = rx_byte;
                    state_d = has_payload ? S_PAYLOAD : S_CSUM;
                end else if (timeout) begin
                    state_d = S_IDLE;
                    idle_d  = 32'd0;
                end
            end
            S_PAYLOAD: begin
                if (rx_dv) begin
                    shadow_d = {shadow_q[55:0], rx_byte};
                    csum_d   = csum_q ^ rx_byte;
                    cnt_d    = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = S_CSUM;
                    end
                end else if (timeout) begin
                    state_d = S_IDLE;
                    idle_d  = 32'd0;
                end
            end
            S_CSUM: begin
                if (rx_dv) begin
                    csum_ok_d = (rx_byte == csum_q) && known_cmd;
                    state_d   = S_EXEC;
                end else if (timeout) begin
                    state_d = S_IDLE;
                    idle_d  = 32'd0;
                end
            end
            S_EXEC: begin
                state_d = S_TX_SEND;
                rem_d   = 4'd1;
                reply_d = 64'h0;
                unique case (1'b1)
                    !csum_ok_q: begin
                        txb_d = NAK_BYTE;
                    end
                    csum_ok_q && (cmd_q == CMD_SET): begin
                        phase_d = shadow_q;
                        inc_d   = 1'b1;
                        txb_d   = ACK_BYTE;
                    end
                    csum_ok_q && (cmd_q == CMD_ADD): begin
                        phase_d = phase_q + shadow_q;
                        inc_d   = 1'b1;
                        txb_d   = ACK_BYTE;
                    end
                    default: begin
                        // QUERY: freeze the word now so all 8 bytes agree.
                        txb_d   = ACK_BYTE;
                        reply_d = phase_q;
                        rem_d   = 4'd9;
                    end
                endcase
            end
            S_TX_SEND: begin
                state_d = S_TX_WAIT;
            end
            S_TX_WAIT: begin
                if (tx_done) begin
                    if (rem_q <= 4'd1) begin
                        state_d = S_IDLE;
                        rem_d   = 4'd0;
                    end else begin
                        txb_d   = reply_q[63:56];
                        reply_d = {reply_q[55:0], 8'h00};
                        rem_d   = rem_q - 4'd1;
                        state_d = S_TX_SEND;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign phase_inc  = phase_q;
    assign inc_update = inc_q;
    assign tx_dv      = (state_q == S_TX_SEND);
    assign tx_byte    = txb_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_tune_cmd_decoder.sv
// Bench for tune_cmd_decoder: fixed frame table, timeout and reset
// corners, then random frames against a frame-level reference model.
module tb_tune_cmd_decoder;

    localparam int          T       = 100;
    localparam logic [63:0] RST_INC = 64'h0104376A9DD10437;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_dv;
    logic [7:0]  rx_byte;
    logic        tx_done = 1'b0;
    logic [63:0] phase_inc;
    logic        inc_update;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic        busy;

    always #5 clk = ~clk;

    tune_cmd_decoder #(
        .RESET_INC   (RST_INC),
        .TIMEOUT_CLKS(T)
    ) dut (
        .osc_clk   (clk),
        .reset     (reset),
        .rx_dv     (rx_dv),
        .rx_byte   (rx_byte),
        .tx_done   (tx_done),
        .phase_inc (phase_inc),
        .inc_update(inc_update),
        .tx_dv     (tx_dv),
        .tx_byte   (tx_byte),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] txq[$];
    int  inc_cnt   = 0;
    int  dv_cnt    = 0;
    bit  pending   = 1'b0;
    bit  hold_done = 1'b0;
    int  dly       = 0;
    logic [63:0] mphase;

    // UART transmitter model: records bytes, answers with tx_done later.
    always @(negedge clk) begin
        tx_done = 1'b0;
        if (reset) begin
            pending = 1'b0;
        end else begin
            if (inc_update) inc_cnt++;
            if (tx_dv) begin
                dv_cnt++;
                checks++;
                if (pending) begin
                    errors++;
                    $display("FAIL tx_dv_gating: tx_dv=1 required 0 before tx_done");
                end
                txq.push_back(tx_byte);
                pending = 1'b1;
                dly = $urandom_range(1, 4);
            end else if (pending && !hold_done) begin
                dly--;
                if (dly <= 0) begin
                    tx_done = 1'b1;
                    pending = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        rx_byte = b;
        rx_dv   = 1'b1;
        @(posedge clk);
        #1;
        rx_dv   = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int k = 0; k < 400; k++) begin
            if (!busy) break;
            @(posedge clk);
            #1;
        end
        chk({name, "_idle"}, busy, 1'b0);
    endtask

    task automatic chk_reply(input string name, input logic [7:0] exp[$],
                             input int incs);
        logic [7:0] got;
        chk({name, "_len"}, txq.size(), exp.size());
        for (int j = 0; j < exp.size(); j++) begin
            got = (j < txq.size()) ? txq[j] : 8'hxx;
            chk($sformatf("%s_byte%0d", name, j), got, exp[j]);
        end
        chk({name, "_incs"}, inc_cnt, incs);
        chk({name, "_phase"}, phase_inc, mphase);
    endtask

    // Frame-level reference: builds the frame, predicts reply and word.
    task automatic run_frame(input string name, input logic [7:0] cmd,
                             input logic [63:0] pay, input bit bad,
                             input int maxgap, input int long_idx);
        logic [7:0] fr[$];
        logic [7:0] exp[$];
        logic [7:0] cs;
        logic [7:0] pb;
        int n;
        int incs;
        fr = {8'hA5, cmd};
        cs = cmd;
        n = (cmd == 8'h01 || cmd == 8'h02) ? 8 : 0;
        for (int i = 0; i < n; i++) begin
            pb = pay[63 - 8 * i -: 8];
            fr.push_back(pb);
            cs ^= pb;
        end
        fr.push_back(bad ? ~cs : cs);
        incs = 0;
        if (bad || cmd == 8'h00 || cmd > 8'h03) begin
            exp = {8'h15};
        end else if (cmd == 8'h01) begin
            mphase = pay;
            incs = 1;
            exp = {8'h06};
        end else if (cmd == 8'h02) begin
            mphase = mphase + pay;
            incs = 1;
            exp = {8'h06};
        end else begin
            exp = {8'h06};
            for (int i = 0; i < 8; i++) exp.push_back(mphase[63 - 8 * i -: 8]);
        end
        txq.delete();
        inc_cnt = 0;
        for (int i = 0; i < fr.size(); i++) begin
            send_byte(fr[i], (i == long_idx) ? T - 1 : $urandom_range(0, maxgap));
        end
        wait_idle(name);
        chk_reply(name, exp, incs);
    endtask

    typedef struct {
        int          n;
        logic [7:0]  b[11];
        int          rn;
        logic [7:0]  r[9];
        logic [63:0] ph;
        int          incs;
        bit          inj;
    } vec_t;

    vec_t v[7];

    initial begin
        logic [7:0] eq[$];
        int dv0;
        bit wins;

        v[0] = '{11, '{8'hA5, 8'h01, 8'h01, 8'hB1, 8'hB1, 8'hB1, 8'hB1,
                       8'hB1, 8'hB1, 8'hB1, 8'hB1},
                 1, '{8'h06, 0, 0, 0, 0, 0, 0, 0, 0},
                 64'h01B1B1B1B1B1B1B1, 1, 1'b0};
        v[1] = '{11, '{8'hA5, 8'h02, 8'h00, 8'h04, 8'h56, 8'h41, 8'hC6,
                       8'hE5, 8'h9D, 8'hF0, 8'h5F},
                 1, '{8'h06, 0, 0, 0, 0, 0, 0, 0, 0},
                 64'h01B607F378974FA1, 1, 1'b0};
        v[2] = '{3, '{8'hA5, 8'h03, 8'h03, 0, 0, 0, 0, 0, 0, 0, 0},
                 9, '{8'h06, 8'h01, 8'hB6, 8'h07, 8'hF3, 8'h78, 8'h97,
                      8'h4F, 8'hA1},
                 64'h01B607F378974FA1, 0, 1'b1};
        v[3] = '{11, '{8'hA5, 8'h01, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11,
                       8'h11, 8'h11, 8'h11, 8'h00},
                 1, '{8'h15, 0, 0, 0, 0, 0, 0, 0, 0},
                 64'h01B607F378974FA1, 0, 1'b0};
        v[4] = '{3, '{8'hA5, 8'h07, 8'h07, 0, 0, 0, 0, 0, 0, 0, 0},
                 1, '{8'h15, 0, 0, 0, 0, 0, 0, 0, 0},
                 64'h01B607F378974FA1, 0, 1'b0};
        v[5] = '{11, '{8'hA5, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                       8'hFF, 8'hFF, 8'hFF, 8'h01},
                 1, '{8'h06, 0, 0, 0, 0, 0, 0, 0, 0},
                 64'hFFFFFFFFFFFFFFFF, 1, 1'b0};
        v[6] = '{11, '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                       8'h00, 8'h00, 8'h02, 8'h00},
                 1, '{8'h06, 0, 0, 0, 0, 0, 0, 0, 0},
                 64'h0000000000000001, 1, 1'b0};

        reset   = 1'b1;
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_phase", phase_inc, RST_INC);
        chk("rst_tx_dv", tx_dv, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_inc_update", inc_update, 1'b0);
        chk("rst_tx_byte", tx_byte, 8'h00);
        mphase = RST_INC;

        for (int i = 0; i < 7; i++) begin
            txq.delete();
            inc_cnt = 0;
            for (int j = 0; j < v[i].n; j++) send_byte(v[i].b[j], 0);
            if (i == 0) begin
                chk("exec_inc_update", inc_update, 1'b0);
                chk("exec_phase", phase_inc, RST_INC);
                @(posedge clk);
                #1;
                chk("post_exec_inc_update", inc_update, 1'b1);
                chk("post_exec_phase", phase_inc, v[i].ph);
            end
            if (v[i].inj) begin
                send_byte(8'hA5, 3);
                send_byte(8'hA5, 5);
            end
            wait_idle($sformatf("vec%0d", i));
            mphase = v[i].ph;
            eq.delete();
            for (int j = 0; j < v[i].rn; j++) eq.push_back(v[i].r[j]);
            chk_reply($sformatf("vec%0d", i), eq, v[i].incs);
        end

        // Mid-frame timeout: A5 01 + 3 payload bytes, then silence.
        txq.delete();
        inc_cnt = 0;
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'h56, 0);
        repeat (T - 2) @(posedge clk);
        #1;
        chk("to_busy_before", busy, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("to_busy_after", busy, 1'b0);
        chk("to_no_reply", txq.size(), 0);
        chk("to_no_inc", inc_cnt, 0);
        chk("to_phase", phase_inc, mphase);
        run_frame("after_to", 8'h01, 64'h0123456789ABCDEF, 1'b0, 1, -1);

        // A byte arriving on the expiry cycle keeps the frame alive.
        run_frame("byte_wins", 8'h02, 64'h0000000100000001, 1'b0, 0, 5);

        for (int f = 0; f < 40; f++) begin
            int sel;
            logic [7:0] c;
            sel = $urandom_range(0, 9);
            if (sel < 3) c = 8'h01;
            else if (sel < 6) c = 8'h02;
            else if (sel < 8) c = 8'h03;
            else c = 8'($urandom_range(4, 255));
            run_frame($sformatf("rnd%0d", f), c, {$urandom, $urandom},
                      ($urandom_range(0, 3) == 0), 3, -1);
        end

        // Reset while parked in TX_WAIT.
        hold_done = 1'b1;
        txq.delete();
        send_byte(8'hA5, 0);
        send_byte(8'h03, 0);
        send_byte(8'h03, 0);
        for (int k = 0; k < 50; k++) begin
            if (pending) break;
            @(posedge clk);
            #1;
        end
        chk("rst_mid_reached_wait", pending, 1'b1);
        chk("rst_mid_first_byte", (txq.size() > 0) ? txq[0] : 8'hxx, 8'h06);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        hold_done = 1'b0;
        dv0 = dv_cnt;
        chk("rst_mid_phase", phase_inc, RST_INC);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_tx_byte", tx_byte, 8'h00);
        repeat (30) @(posedge clk);
        #1;
        chk("rst_mid_no_tx_dv", dv_cnt, dv0);
        wins = (tx_dv == 1'b0);
        chk("rst_mid_tx_dv_low", wins, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tune_cmd_decoder.md
TUNE_CMD_DECODER -- requirements
Module: tune_cmd_decoder

Interface
REQ-001 The block SHALL have parameter RESET_INC, default 64'h0104376A9DD10437, which is the phase increment loaded at reset (540 kHz at 136 MHz).
REQ-002 The block SHALL have parameter TIMEOUT_CLKS, default 1000000, which is the mid-frame inter-byte timeout in clocks.
REQ-003 The block SHALL have port osc_clk  in  1: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset  in  1: synchronous, active-high reset.
REQ-005 The block SHALL have port rx_dv  in  1: one-cycle pulse from the UART receiver meaning rx_byte is valid.
REQ-006 The block SHALL have port rx_byte  in  8: the received byte.
REQ-007 The block SHALL have port tx_done  in  1: one-cycle pulse from the UART transmitter meaning the byte has finished.
REQ-008 The block SHALL have port phase_inc  out  64: the NCO tuning word.
REQ-009 The block SHALL have port inc_update  out  1: one-cycle pulse on each phase_inc write.
REQ-010 The block SHALL have port tx_dv  out  1: one-cycle request to the transmitter to send tx_byte.
REQ-011 The block SHALL have port tx_byte  out  8: the reply byte.
REQ-012 The block SHALL have port busy  out  1: high in any state other than IDLE.

Function
REQ-013 The frame format SHALL be: 0xA5 sync, CMD, N payload bytes sent MSB first, then CSUM.
- CSUM = XOR of CMD and all payload bytes.
- CMD 0x01 SET has N=8; CMD 0x02 ADD has N=8; CMD 0x03 QUERY has N=0.
REQ-014 The FSM SHALL have states IDLE, CMD, PAYLOAD, CSUM, EXEC, TX_SEND, TX_WAIT.
REQ-015 In IDLE, the FSM SHALL discard every byte except 0xA5; on 0xA5 it goes to CMD.
REQ-016 In CMD, the FSM SHALL latch the command byte and go to PAYLOAD if N=8, or to CSUM if N=0.
- An unknown CMD is still latched; the FSM then goes to CSUM, consuming no payload.
REQ-017 PAYLOAD SHALL shift 8 bytes into a 64-bit shadow register using a 3-bit counter, then go to CSUM.
REQ-018 CSUM SHALL compare the received byte against the running XOR, then go to EXEC.
REQ-019 EXEC SHALL last one cycle and SHALL act as follows:
- On a checksum match with SET: phase_inc <= shadow and inc_update = 1.
- On a checksum match with ADD: phase_inc <= phase_inc + shadow, mod 2^64 (wrap, no saturation), and inc_update = 1.
- On a checksum match with QUERY: phase_inc is unchanged.
- On a checksum mismatch or unknown CMD: phase_inc is unchanged and the reply is NAK.
REQ-020 The reply SHALL be queued in EXEC as follows:
- ACK 0x06 for valid SET/ADD.
- ACK 0x06 followed by the 8 bytes of phase_inc, MSB first, for QUERY.
- NAK 0x15 otherwise.
REQ-021 QUERY SHALL snapshot phase_inc in EXEC, so the reply is coherent.
REQ-022 phase_inc and inc_update SHALL change on the edge that leaves EXEC, i.e. 1 clock after the edge that samples the CSUM rx_dv.
REQ-023 In TX_SEND, tx_dv SHALL be high for exactly one cycle with tx_byte valid, and the FSM then goes to TX_WAIT.
REQ-024 In TX_WAIT, the FSM SHALL hold tx_byte and wait for tx_done, then go to TX_SEND for the next byte, or to IDLE after the last byte.
REQ-025 tx_dv SHALL never assert again before tx_done has been received for the previous byte.
REQ-026 In EXEC, TX_SEND and TX_WAIT, the FSM SHALL ignore rx_dv; those bytes are dropped.
REQ-027 A tx_done pulse in any state other than TX_WAIT SHALL be ignored.
REQ-028 In CMD, PAYLOAD and CSUM, a 32-bit idle counter SHALL clear on every rx_dv.
- When the counter reaches TIMEOUT_CLKS-1, the FSM SHALL return to IDLE with no reply and phase_inc unchanged.
REQ-029 If a timeout and rx_dv occur in the same cycle, the byte SHALL win and the timeout is discarded.
REQ-030 A 0xA5 byte received inside a frame SHALL be treated as data, not as a resync.

Reset
REQ-031 On reset high at a clock edge, the block SHALL set:
- state = IDLE;
- phase_inc = RESET_INC;
- inc_update = 0, tx_dv = 0, tx_byte = 0x00, busy = 0;
- counters and shadow = 0.
REQ-032 Reset mid-frame or mid-reply SHALL abort the operation immediately, and no further tx_dv SHALL be issued.

Verification
REQ-033 After reset, with no stimulus: phase_inc = 0x0104376A9DD10437, tx_dv = 0, busy = 0.
REQ-034 Send A5 01 01 B1 B1 B1 B1 B1 B1 B1 B1 -> phase_inc = 0x01B1B1B1B1B1B1B1, one inc_update pulse, reply 0x06.
REQ-035 Then send A5 02 00 04 56 41 C6 E5 9D F0 5F -> phase_inc = 0x01B607F378974FA1, reply 0x06.
- Repeat starting from phase_inc = 0xFFFFFFFFFFFFFFFF with payload 0x0000000000000002 (CSUM 0x00) -> phase_inc = 0x0000000000000001.
REQ-036 Send A5 03 03 -> replies 06 01 B6 07 F3 78 97 4F A1, each tx_dv gated by the preceding tx_done.
- An rx_dv injected during the reply has no effect.
REQ-037 Send a SET frame with CSUM 0x00 -> reply 0x15, no inc_update.
- Send A5 07 07 -> reply 0x15.
REQ-038 Send A5 01 then 3 payload bytes, then idle TIMEOUT_CLKS cycles (set TIMEOUT_CLKS=100) -> busy = 0, no reply.
- A subsequent valid frame is accepted.
- Asserting reset during TX_WAIT -> tx_dv stays 0 and phase_inc = RESET_INC.
